// File: rtl/sdc_rd_blk_sink.sv
// sdc_rd_blk_sink: sink for the single-block read deserializer (sdc_clk domain).
// Writes each strobed 64-bit word to BRAM at base_addr + word index, checks the
// block CRC16-CCITT against the received CRC and reports a one-shot block status.
// Build option: define SDC_RD_CRC_CHK_EN to build the 2-bit/clock CRC engine;
// without it crc_err is tied low and CRC_WAIT passes straight through to CHECK.
module sdc_rd_blk_sink #(
   parameter int unsigned ADDR_W        = 9,
   parameter int unsigned WORDS_PER_BLK = 64
) (
   input  logic              sdc_clk,
   input  logic              reset,
   input  logic              i_blk_start,
   input  logic [ADDR_W-1:0] i_base_addr,
   input  logic              i_latch_wrd_strb,
   input  logic [63:0]       i_dat_wrd,
   input  logic              i_latch_crc_strb,
   input  logic [15:0]       i_crc_16,
   output logic              o_bram_we,
   output logic [ADDR_W-1:0] o_bram_addr,
   output logic [63:0]       o_bram_wdat,
   output logic [7:0]        o_wrd_cnt,
   output logic              o_blk_done,
   output logic              o_crc_err,
   output logic              o_len_err,
   output logic              o_ovr_err
);

   typedef enum logic [2:0] {
      StIdle    = 3'd0,
      StRun     = 3'd1,
      StCrcWait = 3'd2,
      StCheck   = 3'd3,
      StDone    = 3'd4
   } state_e;

   state_e            r_state;
   logic [ADDR_W-1:0] r_base;
   logic [7:0]        r_wrd_cnt;
   logic              r_bram_we;
   logic [ADDR_W-1:0] r_bram_addr;
   logic [63:0]       r_bram_wdat;
   logic              r_blk_done;
   logic              r_len_err;
   logic              r_ovr_err;

   logic              w_eng_busy;
   logic              w_room;
   logic              w_accept;
   logic              w_ovr;
   logic [7:0]        w_cnt_after;
   logic [ADDR_W-1:0] w_wr_addr;

   assign w_room      = (r_wrd_cnt < 8'(WORDS_PER_BLK));
   assign w_accept    = (r_state == StRun) && i_latch_wrd_strb && w_room && !w_eng_busy;
   assign w_ovr       = (r_state == StRun) && i_latch_wrd_strb && !w_accept;
   // A word accepted together with the CRC strobe counts toward the length check.
   assign w_cnt_after = r_wrd_cnt + {7'd0, w_accept};
   // Address wraps silently modulo 2^ADDR_W.
   assign w_wr_addr   = r_base + ADDR_W'(r_wrd_cnt);

   // Block FSM: word acceptance, BRAM write port, length/overrun status, done pulse.
   always_ff @(posedge sdc_clk) begin
      if (reset) begin
         r_state     <= StIdle;
         r_base      <= '0;
         r_wrd_cnt   <= '0;
         r_bram_we   <= 1'b0;
         r_bram_addr <= '0;
         r_bram_wdat <= '0;
         r_blk_done  <= 1'b0;
         r_len_err   <= 1'b0;
         r_ovr_err   <= 1'b0;
      end else if (i_blk_start) begin
         r_state    <= StRun;
         r_base     <= i_base_addr;
         r_wrd_cnt  <= '0;
         r_bram_we  <= 1'b0;
         r_blk_done <= 1'b0;
         r_len_err  <= 1'b0;
         r_ovr_err  <= 1'b0;
      end else begin
         r_bram_we  <= w_accept;
         r_blk_done <= 1'b0;
         if (w_accept) begin
            r_bram_addr <= w_wr_addr;
            r_bram_wdat <= i_dat_wrd;
            r_wrd_cnt   <= r_wrd_cnt + 8'd1;
         end
         if (w_ovr) begin
            r_ovr_err <= 1'b1;
         end
         case (r_state)
            StIdle: ;
            StRun: begin
               if (i_latch_crc_strb) begin
                  r_state <= StCrcWait;
                  if (w_cnt_after != 8'(WORDS_PER_BLK)) begin
                     r_len_err <= 1'b1;
                  end
               end
            end
            StCrcWait: begin
               if (!w_eng_busy) begin
                  r_state <= StCheck;
               end
            end
            StCheck: begin
               r_blk_done <= 1'b1;
               r_state    <= StDone;
            end
            StDone: begin
               r_state <= StIdle;
            end
            default: r_state <= StIdle;
         endcase
      end
   end

`ifdef SDC_RD_CRC_CHK_EN
   logic [63:0] r_shift;
   logic [4:0]  r_step;
   logic        r_busy;
   logic [15:0] r_crc_acc;
   logic [15:0] r_crc_rx;
   logic        r_crc_err;

   // CRC16-CCITT (poly 0x1021), two bits per call, bits[1] first.
   function automatic logic [15:0] f_crc2(input logic [15:0] crc, input logic [1:0] bits);
      logic [15:0] c;
      c = crc;
      for (int i = 1; i >= 0; i--) begin
         c = {c[14:0], 1'b0} ^ ((c[15] ^ bits[i]) ? 16'h1021 : 16'h0000);
      end
      return c;
   endfunction

   assign w_eng_busy = r_busy;

   // CRC engine: 32 cycles per word, MSB first; compares against received CRC in CHECK.
   always_ff @(posedge sdc_clk) begin
      if (reset) begin
         r_shift   <= '0;
         r_step    <= '0;
         r_busy    <= 1'b0;
         r_crc_acc <= '0;
         r_crc_rx  <= '0;
         r_crc_err <= 1'b0;
      end else if (i_blk_start) begin
         r_step    <= '0;
         r_busy    <= 1'b0;
         r_crc_acc <= '0;
         r_crc_err <= 1'b0;
      end else begin
         if (w_accept) begin
            r_shift <= i_dat_wrd;
            r_busy  <= 1'b1;
            r_step  <= '0;
         end else if (r_busy) begin
            r_crc_acc <= f_crc2(r_crc_acc, r_shift[63:62]);
            r_shift   <= {r_shift[61:0], 2'b00};
            r_step    <= r_step + 5'd1;
            if (r_step == 5'd31) begin
               r_busy <= 1'b0;
            end
         end
         if ((r_state == StRun) && i_latch_crc_strb) begin
            r_crc_rx <= i_crc_16;
         end
         if (r_state == StCheck) begin
            r_crc_err <= (r_crc_acc != r_crc_rx);
         end
      end
   end

   assign o_crc_err = r_crc_err;
`else
   logic w_unused_crc;

   assign w_eng_busy   = 1'b0;
   assign w_unused_crc = ^i_crc_16;
   assign o_crc_err    = 1'b0;
`endif

   assign o_bram_we   = r_bram_we;
   assign o_bram_addr = r_bram_addr;
   assign o_bram_wdat = r_bram_wdat;
   assign o_wrd_cnt   = r_wrd_cnt;
   assign o_blk_done  = r_blk_done;
   assign o_len_err   = r_len_err;
   assign o_ovr_err   = r_ovr_err;

endmodule
